// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
//   Time-multiplexed scan controller for common-anode 7-segment digit arrays.
//   One digit is lit at a time through a shared active-low segment bus, with
//   an all-dark gap between digits to suppress ghosting. New digit data is
//   staged in a pending register and only copied to the visible register at
//   a frame boundary, so a single frame never mixes old and new values.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     When defined, a zero digit whose higher digits are all zero is blanked
//     (digit 0 is always shown). When undefined, every digit is decoded as-is.

module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  // One shared counter serves both phases, so it is sized for the longer one.
  localparam int CNT_TOP = ((REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES) - 1;
  localparam int CNT_W   = (CNT_TOP < 1) ? 1 : $clog2(CNT_TOP + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  // With no gap configured, the post-reset BLANK state still lasts one cycle.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF    = 7'b1111111;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic [4*NUM_DIGITS-1:0] pend_reg;
  logic                    pend_valid;

  logic [3:0]              cur_digit;
  logic                    lead_blank;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  // BCD to active-low {a,b,c,d,e,f,g}; non-decimal codes are forced dark.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Scan position register: phase, dwell counter and current digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Next scan position; everything holds while en is low. wrap marks the
  // frame boundary, i.e. the cycle on which idx returns to digit 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    wrap       = 1'b0;
    if (en) begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_next = ST_SHOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_next   = '0;
            state_next = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
            if (idx == IDX_LAST) begin
              idx_next = '0;
              wrap     = 1'b1;
            end else begin
              idx_next = idx + IDX_W'(1);
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_BLANK;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Select the visible nibble for the digit currently being scanned.
  always_comb begin
    cur_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit = disp_reg[4*k +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 is excluded so that a value of zero still shows "0".
  always_comb begin
    lead_blank = 1'b0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        lead_blank = ((disp_reg >> (4*k)) == '0);
      end
    end
  end
`else
  assign lead_blank = 1'b0;
`endif

  // Pin values for the next cycle: dark unless enabled and in the lit phase.
  always_comb begin
    seg_next = SEG_OFF;
    an_next  = '1;
    if (en && (state == ST_SHOW)) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_next[k] = (idx != IDX_W'(k));
      end
      seg_next = lead_blank ? SEG_OFF : decode(cur_digit);
    end
  end

  // Registered pin drivers keep the board outputs glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_next;
      an         <= an_next;
      frame_tick <= wrap;
    end
  end

  // Double-buffered digit data: loads land in pend_reg and are promoted at the
  // frame boundary; a load coinciding with the boundary goes straight through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
    end else if (load && wrap) begin
      disp_reg   <= digits_in;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_reg   <= digits_in;
      pend_valid <= 1'b1;
    end else if (wrap && pend_valid) begin
      disp_reg   <= pend_reg;
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller
//   Bench for seg7_scan_controller with NUM_DIGITS=4, REFRESH_DIV=4,
//   BLANK_CYCLES=2 (24-cycle frame). A frame-position model predicts the pins
//   every cycle; directed literal checks pin the model to hand-derived values.
//   Honours LEADING_ZERO_BLANK_EN the same way as the design.

module tb_seg7_scan_controller;

  localparam int NUM_DIGITS   = 4;
  localparam int REFRESH_DIV  = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int PER          = REFRESH_DIV + BLANK_CYCLES;
  localparam int FRAME        = PER * NUM_DIGITS;

  localparam logic [6:0] OFF = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'b1111111;
`else
  localparam logic [6:0] HI_ZERO = 7'b0000001;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic        en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: enabled-cycle position within the frame plus data buffers.
  int          m_t    = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv   = 1'b0;
  logic [6:0]  exp_seg  = OFF;
  logic [3:0]  exp_an   = 4'hF;
  logic        exp_tick = 1'b0;

  seg7_scan_controller #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .digits_in (digits_in),
    .en        (en),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Edge counter since the last reset release, used to place directed checks.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] model_seg(input logic [15:0] v, input int k);
    logic [3:0] d;
    d = 4'((v >> (4*k)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (k != 0 && (v >> (4*k)) == 16'd0) return OFF;
`endif
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return OFF;
    endcase
  endfunction

  // Reference model: position t counts enabled cycles modulo the frame; the
  // first BLANK_CYCLES of each digit slot are dark, the rest light digit t/PER.
  initial begin : model
    int   pos;
    int   dig;
    logic wrap;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
        exp_seg = OFF; exp_an = 4'hF; exp_tick = 1'b0;
      end else begin
        wrap = 1'b0; exp_seg = OFF; exp_an = 4'hF; exp_tick = 1'b0;
        if (en) begin
          pos = m_t % PER;
          dig = m_t / PER;
          if (pos >= BLANK_CYCLES) begin
            exp_an  = ~(4'b0001 << dig);
            exp_seg = model_seg(m_disp, dig);
          end
          wrap     = (m_t == FRAME - 1);
          exp_tick = wrap;
          m_t      = (m_t + 1) % FRAME;
        end
        if (load && wrap) begin
          m_disp = digits_in; m_pv = 1'b0;
        end else if (load) begin
          m_pend = digits_in; m_pv = 1'b1;
        end else if (wrap && m_pv) begin
          m_disp = m_pend; m_pv = 1'b0;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b (cyc %0d)", name, act[6:0], exp[6:0], cyc);
    end
  endtask

  task automatic expect_lit(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                            input logic tick_e);
    check_output({name, ".an"}, 32'(an), 32'(an_e));
    check_output({name, ".seg"}, 32'(seg), 32'(seg_e));
    check_output({name, ".tick"}, 32'(frame_tick), 32'(tick_e));
  endtask

  // Model comparison on every falling edge, away from the active edge.
  always @(negedge clk) begin
    check_output("model.an", 32'(an), 32'(exp_an));
    check_output("model.seg", 32'(seg), 32'(exp_seg));
    check_output("model.tick", 32'(frame_tick), 32'(exp_tick));
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      failures++;
      $display("[TB] FAIL wait_cyc: got cyc %0d expected %0d", cyc, n);
    end
  endtask

  // Present a one-cycle load strobe starting at the current falling edge.
  task automatic apply_stimulus(input logic [15:0] value);
    load      = 1'b1;
    digits_in = value;
    @(negedge clk);
    load      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; digits_in = '0; en = 1'b0;
    repeat (3) @(negedge clk);
    expect_lit("reset", 4'hF, OFF, 1'b0);
    rst = 1'b0; en = 1'b1;

    $display("[TB] scan after reset");
    wait_cyc(1);  expect_lit("blank0", 4'hF, OFF, 1'b0);
    wait_cyc(2);  expect_lit("blank1", 4'hF, OFF, 1'b0);
    wait_cyc(3);  expect_lit("d0_first", 4'b1110, 7'b0000001, 1'b0);
    wait_cyc(9);  expect_lit("d1_first", 4'b1101, HI_ZERO, 1'b0);
    wait_cyc(23); expect_lit("pre_tick", 4'b0111, HI_ZERO, 1'b0);
    wait_cyc(24); expect_lit("tick", 4'b0111, HI_ZERO, 1'b1);

    $display("[TB] mid-frame load");
    wait_cyc(30); apply_stimulus(16'h1234);
    wait_cyc(33); expect_lit("old_frame", 4'b1101, HI_ZERO, 1'b0);
    wait_cyc(48); expect_lit("tick2", 4'b0111, HI_ZERO, 1'b1);
    wait_cyc(51); expect_lit("new_d0", 4'b1110, 7'b1001100, 1'b0);
    wait_cyc(57); expect_lit("new_d1", 4'b1101, 7'b0000110, 1'b0);
    wait_cyc(63); expect_lit("new_d2", 4'b1011, 7'b0010010, 1'b0);
    wait_cyc(69); expect_lit("new_d3", 4'b0111, 7'b1001111, 1'b0);

    $display("[TB] double load and boundary load");
    wait_cyc(75); apply_stimulus(16'h1111);
    wait_cyc(80); apply_stimulus(16'h5678);
    wait_cyc(99);  expect_lit("last_d0", 4'b1110, 7'b0000000, 1'b0);
    wait_cyc(105); expect_lit("last_d1", 4'b1101, 7'b0001111, 1'b0);
    wait_cyc(111); expect_lit("last_d2", 4'b1011, 7'b0100000, 1'b0);
    wait_cyc(117); expect_lit("last_d3", 4'b0111, 7'b0100100, 1'b0);
    wait_cyc(119); apply_stimulus(16'h9876);
    wait_cyc(123); expect_lit("bnd_d0", 4'b1110, 7'b0100000, 1'b0);

    $display("[TB] non-decimal codes");
    wait_cyc(125); apply_stimulus(16'hABCD);
    wait_cyc(141); expect_lit("bnd_d3", 4'b0111, 7'b0000100, 1'b0);
    wait_cyc(147); expect_lit("hex_d0", 4'b1110, OFF, 1'b0);
    wait_cyc(153); expect_lit("hex_d1", 4'b1101, OFF, 1'b0);
    wait_cyc(159); expect_lit("hex_d2", 4'b1011, OFF, 1'b0);
    wait_cyc(165); expect_lit("hex_d3", 4'b0111, OFF, 1'b0);

    $display("[TB] enable freeze");
    wait_cyc(166); apply_stimulus(16'h1234);
    wait_cyc(171); expect_lit("pre_freeze", 4'b1110, 7'b1001100, 1'b0);
    wait_cyc(172); en = 1'b0;
    wait_cyc(173); expect_lit("frozen_a", 4'hF, OFF, 1'b0);
    wait_cyc(182); expect_lit("frozen_b", 4'hF, OFF, 1'b0);
    en = 1'b1;
    wait_cyc(183); expect_lit("resume_a", 4'b1110, 7'b1001100, 1'b0);
    wait_cyc(184); expect_lit("resume_b", 4'b1110, 7'b1001100, 1'b0);
    wait_cyc(185); expect_lit("resume_gap", 4'hF, OFF, 1'b0);

    $display("[TB] reset mid-show");
    wait_cyc(190); expect_lit("pre_reset", 4'b1101, 7'b0000110, 1'b0);
    #2 rst = 1'b1;
    #1 expect_lit("async_reset", 4'hF, OFF, 1'b0);
    @(negedge clk); rst = 1'b0;
    wait_cyc(1); expect_lit("rst_blank0", 4'hF, OFF, 1'b0);
    wait_cyc(2); expect_lit("rst_blank1", 4'hF, OFF, 1'b0);
    wait_cyc(3); expect_lit("rst_d0", 4'b1110, 7'b0000001, 1'b0);
    wait_cyc(5); apply_stimulus(16'h0050);
    wait_cyc(27); expect_lit("lz_d0", 4'b1110, 7'b0000001, 1'b0);
    wait_cyc(33); expect_lit("lz_d1", 4'b1101, 7'b0100100, 1'b0);
    wait_cyc(39); expect_lit("lz_d2", 4'b1011, HI_ZERO, 1'b0);
    wait_cyc(45); expect_lit("lz_d3", 4'b0111, HI_ZERO, 1'b0);

    $display("[TB] randomized run");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en   = ($urandom_range(7) != 0);
      load = ($urandom_range(5) == 0);
      for (int k = 0; k < 4; k++) begin
        digits_in[4*k +: 4] = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
      end
      if ($urandom_range(499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
